prog_loader_imem: RTL and testbench

Sink stage directly downstream of the machine-code streamer. It captures the valid/data word stream into an on-chip instruction memory, in order from address 0. It detects end-of-program when valid drops, then releases the processor from reset. After load it serves the fetch stage through a synchronous read port.

---
 rtl/prog_loader_pkg.sv | 21 ++
 rtl/prog_loader_imem_if.sv | 41 ++++
 rtl/imem_ram.sv | 35 +++
 rtl/prog_loader_imem.sv | 130 +++++++++++++
 tb/tb_prog_loader_imem.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader / instruction memory slice.
//   - state_t   : loader FSM states, also exported on the debug port
//   - DEF_*     : default geometry used by the top and by the bus interface
//   - NOP_ENC   : instruction encoding the decoder treats as a no-op; the
//                 loader returns it for unloaded or not-yet-loaded addresses
package prog_loader_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ADDR_W  = 9;
  localparam int DEF_TIMEOUT = 1024;

  localparam logic [DEF_DATA_W-1:0] NOP_ENC = 16'h0000;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,  // waiting for the first word of the program
    S_LOAD = 2'd1,  // streaming words into the memory
    S_DONE = 2'd2,  // program loaded, core released, fetch port live
    S_ERR  = 2'd3   // overflow, core held in reset
  } state_t;

endpackage

// File: rtl/prog_loader_imem_if.sv
// Bus bundle between the loader and its neighbours.
//   in_valid / in_data : word stream from the machine-code streamer
//   rd_en / rd_addr    : fetch request from the processor fetch stage
//   rd_data            : fetch response, one cycle after rd_en
//
// Handshake: the input stream is valid-only. There is no ready; every cycle
// with in_valid=1 carries exactly one word and the sink must take it.
// The fetch port is a plain synchronous read: rd_data reflects the request
// made on the previous edge with rd_en=1 and holds otherwise.
//
// Modports: master = streamer/fetch side, slave = loader.
interface prog_loader_imem_if
  import prog_loader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output in_valid,
    output in_data,
    output rd_en,
    output rd_addr,
    input  rd_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  rd_en,
    input  rd_addr,
    output rd_data
  );

endinterface

// File: rtl/imem_ram.sv
// Simple dual-port instruction RAM: one write port, one synchronous read
// port. Contents are not reset; the loader masks anything not written by
// the current load.
// Ports:
//   clk            clock
//   we_i/waddr_i/wdata_i   write port
//   re_i/raddr_i           read request
//   rdata_o                read data, registered, holds while re_i=0
module imem_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/prog_loader_imem.sv
// Program loader and instruction memory.
// Captures the word stream from the machine-code streamer into imem_ram
// starting at address 0, detects end of program when in_valid drops (or a
// timeout with no words at all), then releases the core from reset and
// serves fetches. More than DEPTH words is an overflow: the core stays in
// reset until rst_b.
// Ports:
//   clk, rst_b   clock, asynchronous active-low reset
//   bus          prog_loader_imem_if.slave (stream in, fetch port)
//   load_done    program loaded (sticky until reset)
//   load_err     overflow seen (sticky until reset)
//   word_count   words stored, ADDR_W+1 bits so a full memory is representable
//   cpu_rst_b    active-low core reset, released one cycle after load_done
//   dbg_state    current FSM state
module prog_loader_imem
  import prog_loader_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                TIMEOUT  = DEF_TIMEOUT,
  parameter logic [DATA_W-1:0] NOP_WORD = NOP_ENC
) (
  input  logic                clk,
  input  logic                rst_b,
  prog_loader_imem_if.slave   bus,
  output logic                load_done,
  output logic                load_err,
  output logic [ADDR_W:0]     word_count,
  output logic                cpu_rst_b,
  output state_t              dbg_state
);

  localparam int              DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  tmo_q, tmo_d;
  logic              cpu_rst_b_q;
  // hit_q remembers whether the last accepted read was to a loaded word,
  // so masking lines up with the RAM's one-cycle read latency.
  logic              hit_q, hit_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_rdata;

  // State register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= S_WAIT;
      wr_ptr_q    <= '0;
      tmo_q       <= '0;
      cpu_rst_b_q <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      tmo_q       <= tmo_d;
      // Release the core the cycle after S_DONE is entered.
      cpu_rst_b_q <= (state_q == S_DONE);
      if (bus.rd_en) begin
        hit_q <= hit_d;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    tmo_d    = tmo_q;
    case (state_q)
      S_WAIT: begin
        // A word arriving on the final timeout cycle still starts a load.
        if (bus.in_valid) begin
          state_d  = S_LOAD;
          wr_ptr_d = (ADDR_W + 1)'(1);
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end
      S_LOAD: begin
        if (!bus.in_valid) begin
          state_d = S_DONE;
        end else if (wr_ptr_q == DEPTH_C) begin
          state_d = S_ERR;
        end else begin
          wr_ptr_d = wr_ptr_q + (ADDR_W + 1)'(1);
        end
      end
      default: begin
        // S_DONE and S_ERR are terminal until reset.
      end
    endcase
    hit_d = (state_q == S_DONE) && ({1'b0, bus.rd_addr} < wr_ptr_q);
  end

  // Output logic
  always_comb begin
    ram_we    = bus.in_valid &&
                ((state_q == S_WAIT) ||
                 ((state_q == S_LOAD) && (wr_ptr_q != DEPTH_C)));
    ram_waddr = (state_q == S_WAIT) ? '0 : wr_ptr_q[ADDR_W-1:0];
    load_done = (state_q == S_DONE);
    load_err  = (state_q == S_ERR);
    word_count = wr_ptr_q;
    cpu_rst_b = cpu_rst_b_q;
    dbg_state = state_q;
    bus.rd_data = hit_q ? ram_rdata : NOP_WORD;
  end

  imem_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (bus.in_data),
    .re_i    (bus.rd_en),
    .raddr_i (bus.rd_addr),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_prog_loader_imem.sv
module tb_prog_loader_imem;
  import prog_loader_pkg::*;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Big instance: default geometry. Small instance: 4 words, TIMEOUT=8.
  prog_loader_imem_if #(.DATA_W(16), .ADDR_W(9)) if_b ();
  prog_loader_imem_if #(.DATA_W(16), .ADDR_W(2)) if_s ();

  logic       b_done, b_err, b_crb;
  logic [9:0] b_wc;
  state_t     b_state;
  logic       s_done, s_err, s_crb;
  logic [2:0] s_wc;
  state_t     s_state;

  prog_loader_imem #(.DATA_W(16), .ADDR_W(9), .TIMEOUT(1024), .NOP_WORD(16'h0000)) dut_b (
    .clk(clk), .rst_b(rst_b), .bus(if_b.slave),
    .load_done(b_done), .load_err(b_err), .word_count(b_wc),
    .cpu_rst_b(b_crb), .dbg_state(b_state)
  );

  prog_loader_imem #(.DATA_W(16), .ADDR_W(2), .TIMEOUT(8), .NOP_WORD(16'h0000)) dut_s (
    .clk(clk), .rst_b(rst_b), .bus(if_s.slave),
    .load_done(s_done), .load_err(s_err), .word_count(s_wc),
    .cpu_rst_b(s_crb), .dbg_state(s_state)
  );

  // Scoreboard counters
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    if_b.in_valid = 1'b0; if_b.in_data = '0; if_b.rd_en = 1'b0; if_b.rd_addr = '0;
    if_s.in_valid = 1'b0; if_s.in_data = '0; if_s.rd_en = 1'b0; if_s.rd_addr = '0;
  endtask

  task automatic do_reset();
    idle_all();
    rst_b = 1'b0;
    tick();
    tick();
    rst_b = 1'b1;
  endtask

  // sel: 0 = big instance, 1 = small instance
  task automatic push(input bit sel, input logic [15:0] d);
    if (sel) begin if_s.in_valid = 1'b1; if_s.in_data = d; end
    else     begin if_b.in_valid = 1'b1; if_b.in_data = d; end
    tick();
  endtask

  task automatic stop_stream(input bit sel);
    if (sel) if_s.in_valid = 1'b0;
    else     if_b.in_valid = 1'b0;
    tick();
  endtask

  task automatic rd_chk(input bit sel, input int addr, input logic [15:0] exp, input string tag);
    if (sel) begin if_s.rd_en = 1'b1; if_s.rd_addr = 2'(addr); end
    else     begin if_b.rd_en = 1'b1; if_b.rd_addr = 9'(addr); end
    tick();
    if_s.rd_en = 1'b0;
    if_b.rd_en = 1'b0;
    check(tag, 32'(sel ? if_s.rd_data : if_b.rd_data), 32'(exp));
  endtask

  initial begin
    idle_all();

    // Reset state
    do_reset();
    check("rst_done", 32'(b_done), 32'd0);
    check("rst_err", 32'(b_err), 32'd0);
    check("rst_wc", 32'(b_wc), 32'd0);
    check("rst_crb", 32'(b_crb), 32'd0);
    check("rst_rdata", 32'(if_b.rd_data), 32'h0);
    check("rst_state", 32'(b_state), 32'(S_WAIT));

    // 1. Normal load
    push(1'b0, 16'hA1B2);
    push(1'b0, 16'hC3D4);
    push(1'b0, 16'hE5F6);
    check("n_pre_done", 32'(b_done), 32'd0);
    stop_stream(1'b0);
    check("n_done", 32'(b_done), 32'd1);
    check("n_wc", 32'(b_wc), 32'd3);
    check("n_crb_same", 32'(b_crb), 32'd0);
    tick();
    check("n_crb_next", 32'(b_crb), 32'd1);
    rd_chk(1'b0, 0, 16'hA1B2, "n_rd0");
    rd_chk(1'b0, 1, 16'hC3D4, "n_rd1");
    rd_chk(1'b0, 2, 16'hE5F6, "n_rd2");
    if_b.rd_addr = 9'd0;
    tick();
    check("n_rd_hold", 32'(if_b.rd_data), 32'hE5F6);
    rd_chk(1'b0, 3, 16'h0000, "n_rd3");
    rd_chk(1'b0, 511, 16'h0000, "n_rd511");

    // 6. Post-done stray input
    push(1'b0, 16'hFFFF);
    push(1'b0, 16'hFFFF);
    push(1'b0, 16'hFFFF);
    stop_stream(1'b0);
    check("p_wc", 32'(b_wc), 32'd3);
    check("p_done", 32'(b_done), 32'd1);
    check("p_crb", 32'(b_crb), 32'd1);
    rd_chk(1'b0, 0, 16'hA1B2, "p_rd0");
    rd_chk(1'b0, 1, 16'hC3D4, "p_rd1");
    rd_chk(1'b0, 2, 16'hE5F6, "p_rd2");
    rd_chk(1'b0, 3, 16'h0000, "p_rd3");

    // 5. Reset mid-load
    do_reset();
    push(1'b0, 16'h1111);
    push(1'b0, 16'h2222);
    if_b.in_valid = 1'b0;
    rst_b = 1'b0;
    #2;
    check("m_wc_rst", 32'(b_wc), 32'd0);
    tick();
    rst_b = 1'b1;
    push(1'b0, 16'h1234);
    stop_stream(1'b0);
    check("m_done", 32'(b_done), 32'd1);
    check("m_wc", 32'(b_wc), 32'd1);
    rd_chk(1'b0, 0, 16'h1234, "m_rd0");
    rd_chk(1'b0, 1, 16'h0000, "m_rd1_stale");

    // 2. Overflow on the 4-word instance
    do_reset();
    push(1'b1, 16'h0011);
    push(1'b1, 16'h0022);
    push(1'b1, 16'h0033);
    push(1'b1, 16'h0044);
    check("o_err_pre", 32'(s_err), 32'd0);
    check("o_wc_full", 32'(s_wc), 32'd4);
    push(1'b1, 16'h0055);
    check("o_err", 32'(s_err), 32'd1);
    check("o_wc", 32'(s_wc), 32'd4);
    check("o_done", 32'(s_done), 32'd0);
    stop_stream(1'b1);
    tick();
    check("o_crb", 32'(s_crb), 32'd0);
    check("o_state", 32'(s_state), 32'(S_ERR));
    for (int a = 0; a < 4; a++) rd_chk(1'b1, a, 16'h0000, "o_rd_nop");

    // 3. Exact fill
    do_reset();
    push(1'b1, 16'h0101);
    push(1'b1, 16'h0202);
    push(1'b1, 16'h0303);
    push(1'b1, 16'h0404);
    stop_stream(1'b1);
    check("f_done", 32'(s_done), 32'd1);
    check("f_wc", 32'(s_wc), 32'd4);
    check("f_err", 32'(s_err), 32'd0);
    tick();
    check("f_crb", 32'(s_crb), 32'd1);
    rd_chk(1'b1, 3, 16'h0404, "f_rd3");
    rd_chk(1'b1, 0, 16'h0101, "f_rd0");

    // 4. Timeout with no words
    do_reset();
    rd_chk(1'b1, 0, 16'h0000, "t_rd_wait");
    for (int i = 1; i < 7; i++) tick();
    check("t_done_pre", 32'(s_done), 32'd0);
    tick();
    check("t_done", 32'(s_done), 32'd1);
    check("t_wc", 32'(s_wc), 32'd0);
    check("t_crb_same", 32'(s_crb), 32'd0);
    tick();
    check("t_crb_next", 32'(s_crb), 32'd1);
    rd_chk(1'b1, 0, 16'h0000, "t_rd0");

    // Word arriving on the last timeout cycle wins
    do_reset();
    for (int i = 0; i < 7; i++) tick();
    push(1'b1, 16'h0AAA);
    check("w_state", 32'(s_state), 32'(S_LOAD));
    check("w_done", 32'(s_done), 32'd0);
    stop_stream(1'b1);
    check("w_wc", 32'(s_wc), 32'd1);
    rd_chk(1'b1, 0, 16'h0AAA, "w_rd0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
